// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM stream controller
package sram_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int RSP_DEPTH  = 2;
  localparam int RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - two-entry read-response FIFO with a registered head
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic                 valid,
  output logic [RSP_CNT_W-1:0] count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             do_pop;
  logic             full;

  assign full   = (count == RSP_CNT_W'(RSP_DEPTH));
  assign do_pop = pop & (count != '0);
  assign valid  = (count != '0);
  assign dout   = head_q;

  // Head always holds the oldest entry so the output never passes through a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (!full) begin
            if (count == '0) head_q <= din;
            else             tail_q <= din;
            count <= count + 1'b1;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          count  <= count - 1'b1;
        end
        2'b11: begin
          if (count == RSP_CNT_W'(1)) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The read-credit rule upstream must keep pushes away from a full FIFO.
  sva_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop));

endmodule

// File: rtl/sram_stream_ctrl.sv
// rtl/sram_stream_ctrl.sv - request/response stream front end for a 64x32 SRAM macro
module sram_stream_ctrl #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_we,
  output logic                  sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  import sram_ctrl_pkg::*;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_WIDTH-1:0]  init_cnt;
  logic                   inflight_q;
  logic [RSP_CNT_W-1:0]   fifo_count;
  logic                   pop;
  logic                   rd_credit;
  logic                   rd_accept;
  logic [2:0]             occupancy;
  logic [2:0]             limit;

  assign pop       = rsp_valid & rsp_ready;
  assign occupancy = 3'(fifo_count) + 3'(inflight_q);
  assign limit     = 3'(RSP_DEPTH) + 3'(pop);
  // A slot freed by this cycle's pop may be reused by a read accepted now.
  assign rd_credit = (occupancy < limit);
  assign rd_accept = req_valid & req_ready & ~req_we;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next state and SRAM/request-channel outputs; RUN passes the request straight to the macro.
  always_comb begin
    state_d    = state_q;
    sram_we    = 1'b0;
    sram_wmask = 1'b1;
    sram_addr  = req_addr;
    sram_din   = req_wdata;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    case (state_q)
      INIT: begin
        sram_we   = rst_n;
        sram_addr = init_cnt;
        sram_din  = '0;
        if (init_cnt == '1) state_d = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        req_ready = req_we | rd_credit;
        sram_we   = req_valid & req_we;
      end
      default: state_d = INIT;
    endcase
  end

  // Zero-fill address counter, one word per cycle while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_cnt <= '0;
    else if (state_q == INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // Marks the cycle in which the macro presents data for the previous read accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= rd_accept;
  end

  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (sram_dout),
    .pop   (pop),
    .dout  (rsp_rdata),
    .valid (rsp_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// tb/tb_sram_stream_ctrl.sv - scoreboard bench for sram_stream_ctrl with a behavioural SRAM
module tb_sram_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        sram_we;
  logic        sram_wmask;
  logic [5:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  logic [31:0] macro [64];
  bit          rand_mode = 0;

  sram_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Behavioural 64x32 macro: write commits at the edge, read data registered one cycle.
  initial for (int i = 0; i < 64; i++) macro[i] = $urandom;
  always @(posedge clk) begin
    if (sram_we && sram_wmask) macro[sram_addr] <= sram_din;
    sram_dout <= macro[sram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  // Called just after rst_n rises at a falling edge; walks the 64 zero-fill cycles.
  task automatic run_init();
    logic [5:0] ia;
    for (int i = 0; i < 64; i++) begin
      ia = i[5:0];
      #1;
      chk("init_cycle", {sram_we, sram_addr, sram_din, init_done, req_ready, rsp_valid},
          {1'b1, ia, 32'h0, 3'b000});
      @(negedge clk);
    end
    #1;
    chk("init_done_after_64", {init_done, sram_we}, 2'b10);
    @(negedge clk);
  endtask

  // Drive a request from a falling edge; returns at the falling edge after the accept.
  task automatic try_req(input bit we, input logic [5:0] a, input logic [31:0] d,
                         input int max_cyc, output bit ok);
    ok = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      #1;
      if (req_ready) begin
        ok = 1;
        if (we) ref_mem[a] = d;
        else    exp_q.push_back(ref_mem[a]);
      end
      @(negedge clk);
    end
    req_valid = 0;
  endtask

  task automatic issue(input bit we, input logic [5:0] a, input logic [31:0] d);
    bit ok;
    try_req(we, a, d, 50, ok);
    chk("req_accept", ok, 1);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks stall stability.
  initial begin
    bit          held = 0;
    logic [31:0] held_data = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        held = 0;
      end else begin
        if (rsp_valid && !rsp_ready) begin
          if (held) chk("rsp_hold_stable", rsp_rdata, held_data);
          held = 1;
          held_data = rsp_rdata;
        end else begin
          held = 0;
        end
        if (rsp_valid && rsp_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else                   chk("rsp_data", rsp_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // Random back-pressure on the response channel during the random phase.
  initial forever begin
    @(negedge clk);
    if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit         ok, a1, a2, a3;
    int         span;
    int         waitc;
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sram_we",   sram_we,   0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1;
    run_init();

    // Zero-filled read, then read-after-write on consecutive cycles.
    rsp_ready = 1;
    issue(0, 6'd17, '0);
    issue(1, 6'd5, 32'hDEADBEEF);
    issue(0, 6'd5, '0);
    @(negedge clk);
    #1;
    chk("raw_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEADBEEF});
    @(negedge clk);

    // Back-to-back reads with no bubble.
    for (int i = 0; i < 8; i++) issue(1, 6'(i), 32'(i * 3));
    rsp_ready = 1;
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      try_req(0, 6'(i), '0, 1, ok);
      chk("b2b_accept", ok, 1);
    end
    repeat (4) @(negedge clk);
    chk("b2b_rsp_count", pop_cyc.size(), 8);
    span = (pop_cyc.size() >= 8) ? pop_cyc[7] - pop_cyc[0] : -1;
    chk("b2b_no_bubble", span, 7);

    // Read credit with the response channel stalled.
    rsp_ready = 0;
    try_req(0, 6'd1, '0, 1, a1);
    try_req(0, 6'd2, '0, 1, a2);
    try_req(0, 6'd3, '0, 1, a3);
    chk("credit_accepts", {a1, a2, a3}, 3'b110);
    req_valid = 1; req_we = 0; req_addr = 6'd3;
    #1;
    chk("read_blocked_full", req_ready, 0);
    @(negedge clk);
    req_valid = 0;
    try_req(1, 6'd9, $urandom, 1, ok);
    chk("write_while_full", ok, 1);
    rsp_ready = 1;
    try_req(0, 6'd3, '0, 10, ok);
    chk("read_after_drain", ok, 1);
    repeat (4) @(negedge clk);
    chk("drained_after_stall", exp_q.size(), 0);

    // Reset with one response queued and one read in flight.
    rsp_ready = 0;
    issue(1, 6'd10, $urandom);
    issue(1, 6'd11, $urandom);
    try_req(0, 6'd10, '0, 1, a1);
    try_req(0, 6'd11, '0, 1, a2);
    chk("pre_reset_accepts", {a1, a2}, 2'b11);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_outputs", {rsp_valid, req_ready, init_done, sram_we}, 4'b0000);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    run_init();
    issue(0, 6'd10, '0);
    issue(0, 6'd11, '0);
    repeat (4) @(negedge clk);
    chk("post_reset_drained", exp_q.size(), 0);

    // Randomized traffic against the reference memory.
    rand_mode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      else issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom);
    end
    rand_mode = 0;
    rsp_ready = 1;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
